// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the pipeline hazard controller.
//   fwd_sel_t  : Execute operand-forward select encoding
//   hz_state_t : hazard scheduler FSM state encoding
//   REG_ZERO   : index of the hard-wired zero register
//   CNT_W      : width of the load-use bubble counter (holds up to 7)
// -----------------------------------------------------------------------------
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RUN        = 2'b00,
        LOAD_STALL = 2'b01,
        MEM_WAIT   = 2'b10
    } hz_state_t;

    localparam int REG_ZERO = 0;
    localparam int CNT_W    = 3;

endpackage

// File: rtl/hazard_controller_forward_sel.sv
// -----------------------------------------------------------------------------
// forward_sel
// Combinational forward-select for one Execute operand. The Memory stage
// holds the younger result, so it wins over Writeback.
// Ports:
//   rs          in  source register of the Execute operand
//   rd_m        in  destination register in Memory
//   reg_write_m in  register-write enable in Memory
//   rd_w        in  destination register in Writeback
//   reg_write_w in  register-write enable in Writeback
//   sel         out forward select (FWD_RF / FWD_WB / FWD_MEM)
// -----------------------------------------------------------------------------
module forward_sel
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] rd_m,
    input  logic                  reg_write_m,
    input  logic [REG_ADDR_W-1:0] rd_w,
    input  logic                  reg_write_w,
    output fwd_sel_t              sel
);

    localparam logic [REG_ADDR_W-1:0] ZERO = REG_ADDR_W'(REG_ZERO);

    always_comb begin
        if (reg_write_m && (rd_m != ZERO) && (rd_m == rs))
            sel = FWD_MEM;
        else if (reg_write_w && (rd_w != ZERO) && (rd_w == rs))
            sel = FWD_WB;
        else
            sel = FWD_RF;
    end

endmodule

// File: rtl/hazard_controller.sv
// -----------------------------------------------------------------------------
// hazard_controller
// Central hazard scheduler for the 5-stage pipeline: operand forwarding,
// load-use bubbles (LOAD_STALL_CYCLES per hazard), data-memory freeze and
// branch/jump flushes, including a flush deferred across a freeze.
// Optional build macro: HAZARD_PERF_EN enables saturating perf counters;
// without it the perf ports are tied to zero.
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   Rs1D, Rs2D                 Decode source registers
//   Rs1E, Rs2E                 Execute source registers
//   RdE, RdM, RdW              destination registers in E / M / W
//   ResultSrcE                 Execute instruction is a load
//   RegWriteM, RegWriteW       register-write enables in M / W
//   PCSrcE                     taken branch/jump resolved in Execute
//   MemReqM, mem_ready         memory access in M, memory completes
//   ForwardA_E, ForwardB_E     operand forward selects
//   StallF/D/E/M, FlushD/E     pipeline register controls
//   hz_state                   current FSM state
//   perf_stall/flush/memwait   performance counters
// -----------------------------------------------------------------------------
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W        = 5,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int PERF_W            = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] Rs1D,
    input  logic [REG_ADDR_W-1:0] Rs2D,
    input  logic [REG_ADDR_W-1:0] Rs1E,
    input  logic [REG_ADDR_W-1:0] Rs2E,
    input  logic [REG_ADDR_W-1:0] RdE,
    input  logic [REG_ADDR_W-1:0] RdM,
    input  logic [REG_ADDR_W-1:0] RdW,
    input  logic                  ResultSrcE,
    input  logic                  RegWriteM,
    input  logic                  RegWriteW,
    input  logic                  PCSrcE,
    input  logic                  MemReqM,
    input  logic                  mem_ready,
    output logic [1:0]            ForwardA_E,
    output logic [1:0]            ForwardB_E,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  StallE,
    output logic                  StallM,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic [1:0]            hz_state,
    output logic [PERF_W-1:0]     perf_stall,
    output logic [PERF_W-1:0]     perf_flush,
    output logic [PERF_W-1:0]     perf_memwait
);

    localparam logic [REG_ADDR_W-1:0] ZERO = REG_ADDR_W'(REG_ZERO);

    // ---------------- forwarding ----------------
    fwd_sel_t fwd_a;
    fwd_sel_t fwd_b;

    forward_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
        .rs          (Rs1E),
        .rd_m        (RdM),
        .reg_write_m (RegWriteM),
        .rd_w        (RdW),
        .reg_write_w (RegWriteW),
        .sel         (fwd_a)
    );

    forward_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
        .rs          (Rs2E),
        .rd_m        (RdM),
        .reg_write_m (RegWriteM),
        .rd_w        (RdW),
        .reg_write_w (RegWriteW),
        .sel         (fwd_b)
    );

    assign ForwardA_E = fwd_a;
    assign ForwardB_E = fwd_b;

    // ---------------- scheduler ----------------
    hz_state_t        state, next_state, eff_state;
    logic [CNT_W-1:0] cnt, next_cnt;
    logic             flush_pending, next_fp;
    logic             freeze, lu, br;
    logic             stall_fd, flush_d, flush_e;

    assign freeze = MemReqM && !mem_ready;
    assign lu     = ResultSrcE && (RdE != ZERO) && ((RdE == Rs1D) || (RdE == Rs2D));
    assign br     = PCSrcE || flush_pending;

    // The cycle that leaves MEM_WAIT behaves like the state it returns to,
    // so remaining bubbles resume without losing a cycle.
    always_comb begin
        if (state == MEM_WAIT)
            eff_state = (cnt != '0) ? LOAD_STALL : RUN;
        else
            eff_state = state;
    end

    // NOTE: every output of this block gets a default first so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        stall_fd   = 1'b0;
        flush_d    = 1'b0;
        flush_e    = 1'b0;
        next_state = state;
        next_cnt   = cnt;
        next_fp    = flush_pending;

        if (freeze) begin
            // Counter is held; a branch seen while frozen is remembered.
            stall_fd   = 1'b1;
            next_state = MEM_WAIT;
            if (PCSrcE)
                next_fp = 1'b1;
        end else begin
            case (eff_state)
                LOAD_STALL: begin
                    if (br) begin
                        flush_d    = 1'b1;
                        flush_e    = 1'b1;
                        next_fp    = 1'b0;
                        next_cnt   = '0;
                        next_state = RUN;
                    end else begin
                        stall_fd   = 1'b1;
                        flush_e    = 1'b1;
                        next_cnt   = cnt - CNT_W'(1);
                        next_state = (cnt == CNT_W'(1)) ? RUN : LOAD_STALL;
                    end
                end
                default: begin
                    next_state = RUN;
                    // Branch beats load-use: the Decode instruction is squashed.
                    if (br) begin
                        flush_d = 1'b1;
                        flush_e = 1'b1;
                        next_fp = 1'b0;
                    end else if (lu) begin
                        stall_fd = 1'b1;
                        flush_e  = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            next_cnt   = CNT_W'(LOAD_STALL_CYCLES - 1);
                            next_state = LOAD_STALL;
                        end
                    end
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= RUN;
            cnt           <= '0;
            flush_pending <= 1'b0;
        end else begin
            state         <= next_state;
            cnt           <= next_cnt;
            flush_pending <= next_fp;
        end
    end

    assign StallF   = stall_fd;
    assign StallD   = stall_fd;
    assign StallE   = freeze;
    assign StallM   = freeze;
    assign FlushD   = flush_d;
    assign FlushE   = flush_e;
    assign hz_state = state;

    // ---------------- performance counters ----------------
`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] stall_q, flush_q, memwait_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q   <= '0;
            flush_q   <= '0;
            memwait_q <= '0;
        end else begin
            if (stall_fd && !(&stall_q))
                stall_q <= stall_q + PERF_W'(1);
            if (flush_d && !(&flush_q))
                flush_q <= flush_q + PERF_W'(1);
            if (freeze && !(&memwait_q))
                memwait_q <= memwait_q + PERF_W'(1);
        end
    end

    assign perf_stall   = stall_q;
    assign perf_flush   = flush_q;
    assign perf_memwait = memwait_q;
`else
    assign perf_stall   = '0;
    assign perf_flush   = '0;
    assign perf_memwait = '0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// -----------------------------------------------------------------------------
// tb_hazard_controller
// Directed bench for hazard_controller. Two instances share all inputs:
// dut_a uses LOAD_STALL_CYCLES = 2, dut_b uses LOAD_STALL_CYCLES = 3.
// Inputs are driven 1 ns after the rising edge; outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_hazard_controller;

    localparam int W  = 5;
    localparam int PW = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [W-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic         ResultSrcE, RegWriteM, RegWriteW, PCSrcE, MemReqM, mem_ready;

    logic [1:0]    a_fa, a_fb, a_st, b_fa, b_fb, b_st;
    logic          a_sf, a_sd, a_se, a_sm, a_fd, a_fe;
    logic          b_sf, b_sd, b_se, b_sm, b_fd, b_fe;
    logic [PW-1:0] a_ps, a_pf, a_pm, b_ps, b_pf, b_pm;

    wire [5:0] a_ctl = {a_sf, a_sd, a_se, a_sm, a_fd, a_fe};
    wire [5:0] b_ctl = {b_sf, b_sd, b_se, b_sm, b_fd, b_fe};

    int total = 0;
    int bad   = 0;

    hazard_controller #(.REG_ADDR_W(W), .LOAD_STALL_CYCLES(2), .PERF_W(PW)) dut_a (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .ResultSrcE(ResultSrcE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .PCSrcE(PCSrcE), .MemReqM(MemReqM), .mem_ready(mem_ready),
        .ForwardA_E(a_fa), .ForwardB_E(a_fb),
        .StallF(a_sf), .StallD(a_sd), .StallE(a_se), .StallM(a_sm),
        .FlushD(a_fd), .FlushE(a_fe), .hz_state(a_st),
        .perf_stall(a_ps), .perf_flush(a_pf), .perf_memwait(a_pm)
    );

    hazard_controller #(.REG_ADDR_W(W), .LOAD_STALL_CYCLES(3), .PERF_W(PW)) dut_b (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .ResultSrcE(ResultSrcE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .PCSrcE(PCSrcE), .MemReqM(MemReqM), .mem_ready(mem_ready),
        .ForwardA_E(b_fa), .ForwardB_E(b_fb),
        .StallF(b_sf), .StallD(b_sd), .StallE(b_se), .StallM(b_sm),
        .FlushD(b_fd), .FlushE(b_fe), .hz_state(b_st),
        .perf_stall(b_ps), .perf_flush(b_pf), .perf_memwait(b_pm)
    );

    task automatic idle();
        Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0;
        RdE = '0; RdM = '0; RdW = '0;
        ResultSrcE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
        PCSrcE = 1'b0; MemReqM = 1'b0; mem_ready = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle();
        #2;
        total++;
        if (a_ctl !== 6'b0 || b_ctl !== 6'b0) begin
            $display("FAIL reset_ctl: got a=%b b=%b want 000000", a_ctl, b_ctl); bad++;
        end
        total++;
        if (a_st !== 2'b00 || b_st !== 2'b00) begin
            $display("FAIL reset_state: got a=%b b=%b want 00", a_st, b_st); bad++;
        end
        total++;
        if (a_fa !== 2'b00 || a_fb !== 2'b00) begin
            $display("FAIL reset_fwd: got %b/%b want 00/00", a_fa, a_fb); bad++;
        end
        total++;
        if (a_ps !== '0 || a_pf !== '0 || a_pm !== '0) begin
            $display("FAIL reset_perf: got %0d/%0d/%0d want 0/0/0", a_ps, a_pf, a_pm); bad++;
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_forwarding();
        RdM = 5'd3; RegWriteM = 1'b1; RdW = 5'd3; RegWriteW = 1'b1;
        Rs1E = 5'd3; Rs2E = 5'd3;
        #1; total++;
        if (a_fa !== 2'b10) begin
            $display("FAIL fwd_mem_priority: got %b want 10", a_fa); bad++;
        end
        total++;
        if (a_fb !== 2'b10) begin
            $display("FAIL fwd_b_mem: got %b want 10", a_fb); bad++;
        end
        RegWriteM = 1'b0;
        #1; total++;
        if (a_fa !== 2'b01) begin
            $display("FAIL fwd_wb: got %b want 01", a_fa); bad++;
        end
        Rs1E = 5'd0;
        #1; total++;
        if (a_fa !== 2'b00 || a_fb !== 2'b01) begin
            $display("FAIL fwd_reg0: got %b/%b want 00/01", a_fa, a_fb); bad++;
        end
        // Writing register 0 never forwards; forwarding still works frozen.
        RdM = 5'd0; RegWriteM = 1'b1; RdW = 5'd7; Rs2E = 5'd7;
        MemReqM = 1'b1; mem_ready = 1'b0;
        #1; total++;
        if (a_fa !== 2'b00 || a_fb !== 2'b01) begin
            $display("FAIL fwd_frozen: got %b/%b want 00/01", a_fa, a_fb); bad++;
        end
        idle();
        tick();
    endtask

    task automatic test_load_use();
        logic [4:0] exp_bub = 5'b00011;
        logic [1:0] exp_st [5] = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
        int nb = 0;
        for (int i = 0; i < 5; i++) begin
            ResultSrcE = (i == 0); RdE = 5'd5; Rs2D = 5'd5;
            #1;
            total++;
            if ((a_sf && a_sd && a_fe) !== exp_bub[i]) begin
                $display("FAIL lu_bubble[%0d]: got %b want %b", i, a_ctl, exp_bub[i]); bad++;
            end
            total++;
            if (a_st !== exp_st[i]) begin
                $display("FAIL lu_state[%0d]: got %b want %b", i, a_st, exp_st[i]); bad++;
            end
            if (b_sf && b_fe) nb++;
            tick();
        end
        total++;
        if (nb != 3) begin
            $display("FAIL lu_bubbles_3: got %0d want 3", nb); bad++;
        end
        idle();
    endtask

    task automatic test_branch_priority();
        ResultSrcE = 1'b1; RdE = 5'd5; Rs2D = 5'd5; PCSrcE = 1'b1;
        #1; total++;
        if (a_ctl !== 6'b000011) begin
            $display("FAIL br_over_lu: got %b want 000011", a_ctl); bad++;
        end
        tick();
        idle();
        #1; total++;
        if (a_st !== 2'b00 || b_st !== 2'b00 || a_ctl !== 6'b0) begin
            $display("FAIL br_no_ls: got st=%b/%b ctl=%b want 00/00 000000", a_st, b_st, a_ctl); bad++;
        end
        tick();
    endtask

    task automatic test_freeze_flush();
        for (int i = 0; i < 3; i++) begin
            MemReqM = 1'b1; mem_ready = 1'b0; PCSrcE = (i == 0);
            #1; total++;
            if (a_ctl !== 6'b111100) begin
                $display("FAIL freeze[%0d]: got %b want 111100", i, a_ctl); bad++;
            end
            tick();
            total++;
            if (a_st !== 2'b10) begin
                $display("FAIL freeze_state[%0d]: got %b want 10", i, a_st); bad++;
            end
        end
        MemReqM = 1'b1; mem_ready = 1'b1; PCSrcE = 1'b0;
        #1; total++;
        if (a_ctl !== 6'b000011) begin
            $display("FAIL deferred_flush: got %b want 000011", a_ctl); bad++;
        end
        tick();
        idle();
        #1; total++;
        if (a_ctl !== 6'b0 || a_st !== 2'b00) begin
            $display("FAIL pending_cleared: got ctl=%b st=%b want 000000 00", a_ctl, a_st); bad++;
        end
        tick();
    endtask

    task automatic test_bubbles_with_freeze();
        int na = 0, nb = 0, nfz = 0;
        for (int i = 0; i < 8; i++) begin
            ResultSrcE = (i == 0); RdE = 5'd5; Rs2D = 5'd5;
            MemReqM = (i == 1 || i == 2); mem_ready = !(i == 1 || i == 2);
            #1;
            if (a_sf && a_fe && !a_se) na++;
            if (b_sf && b_fe && !b_se) nb++;
            if (b_se) nfz++;
            tick();
        end
        idle();
        total++;
        if (nb != 3) begin
            $display("FAIL frz_bubbles_lsc3: got %0d want 3", nb); bad++;
        end
        total++;
        if (na != 2) begin
            $display("FAIL frz_bubbles_lsc2: got %0d want 2", na); bad++;
        end
        total++;
        if (nfz != 2) begin
            $display("FAIL frz_cycles: got %0d want 2", nfz); bad++;
        end
        total++;
        if (a_st !== 2'b00 || b_st !== 2'b00) begin
            $display("FAIL frz_end_state: got %b/%b want 00/00", a_st, b_st); bad++;
        end
    endtask

    task automatic test_reset_mid_stall();
        ResultSrcE = 1'b1; RdE = 5'd5; Rs1D = 5'd5;
        tick();
        idle();
        #1; reset = 1'b0;
        #1; total++;
        if (a_st !== 2'b00 || b_st !== 2'b00 || a_ctl !== 6'b0 || b_ctl !== 6'b0) begin
            $display("FAIL reset_mid_ls: got st=%b/%b ctl=%b/%b want 00/00 0/0", a_st, b_st, a_ctl, b_ctl); bad++;
        end
        reset = 1'b1;
        tick();
        total++;
        if (b_ctl !== 6'b0 || b_st !== 2'b00) begin
            $display("FAIL after_reset_ls: got ctl=%b st=%b want 000000 00", b_ctl, b_st); bad++;
        end
        // A flush remembered during a freeze is discarded by reset.
        MemReqM = 1'b1; mem_ready = 1'b0; PCSrcE = 1'b1;
        tick();
        idle();
        #1; reset = 1'b0;
        #1; reset = 1'b1;
        #1; total++;
        if (a_ctl !== 6'b0) begin
            $display("FAIL reset_drops_pending: got %b want 000000", a_ctl); bad++;
        end
        tick();
    endtask

    task automatic test_perf();
        reset = 1'b0;
        #1; reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            MemReqM = 1'b1; mem_ready = 1'b0;
            tick();
        end
        idle();
        PCSrcE = 1'b1;
        tick();
        idle();
`ifdef HAZARD_PERF_EN
        total++;
        if (a_pm !== 16'd5 || b_pm !== 16'd5) begin
            $display("FAIL perf_memwait: got %0d/%0d want 5", a_pm, b_pm); bad++;
        end
        total++;
        if (a_ps !== 16'd5) begin
            $display("FAIL perf_stall: got %0d want 5", a_ps); bad++;
        end
        total++;
        if (a_pf !== 16'd1) begin
            $display("FAIL perf_flush: got %0d want 1", a_pf); bad++;
        end
`else
        total++;
        if (a_pm !== '0 || a_ps !== '0 || a_pf !== '0) begin
            $display("FAIL perf_tied: got %0d/%0d/%0d want 0/0/0", a_ps, a_pf, a_pm); bad++;
        end
`endif
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch_priority();
        test_freeze_flush();
        test_bubbles_with_freeze();
        test_reset_mid_stall();
        test_perf();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
